// File: rtl/sdm_request_scheduler.sv
// Round-robin scheduler sharing one sparse-distributed-memory array among NUM_REQ requesters.
// Each accepted request is issued to the array once, awaited with a timeout and answered to its owner.
module sdm_request_scheduler #(
    parameter int BIT_WIDTH     = 512,
    parameter int NUM_REQ       = 4,
    parameter int REQ_ID_WIDTH  = 2,
    parameter int TIMEOUT       = 16,
    parameter int TIMEOUT_WIDTH = 5
) (
    input  logic                         clk,
    input  logic                         rstb,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ-1:0]           req_wnr,
    input  logic [NUM_REQ*BIT_WIDTH-1:0] req_addr,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [NUM_REQ-1:0]           rsp_valid,
    output logic                         rsp_success,
    output logic                         rsp_timeout,
    output logic [BIT_WIDTH-1:0]         rsp_data,
    output logic                         busy,
    output logic [BIT_WIDTH-1:0]         sdm_address,
    output logic                         sdm_valid,
    output logic                         sdm_wnr,
    input  logic                         sdm_readValid,
    input  logic                         sdm_readSuccess,
    input  logic [BIT_WIDTH-1:0]         sdm_data
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} stateType;

    stateType                  state;
    logic [REQ_ID_WIDTH-1:0]   ptr;
    logic [REQ_ID_WIDTH-1:0]   latchedId;
    logic [BIT_WIDTH-1:0]      latchedAddr;
    logic                      latchedWnr;
    logic [TIMEOUT_WIDTH-1:0]  waitCount;
    logic [BIT_WIDTH-1:0]      reqAddrArr [NUM_REQ];
    logic [REQ_ID_WIDTH-1:0]   grantIdx;
    logic                      grantFound;
    int                        candidate;

    for (genvar g = 0; g < NUM_REQ; g++) begin : gAddrSplit
        assign reqAddrArr[g] = req_addr[g*BIT_WIDTH +: BIT_WIDTH];
    end

    // Scan downward so the asserted requester closest to ptr (in wrap order) wins last.
    always_comb begin
        grantFound = 1'b0;
        grantIdx   = '0;
        candidate  = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            candidate = int'(ptr) + k;
            if (candidate >= NUM_REQ) candidate = candidate - NUM_REQ;
            if (req_valid[REQ_ID_WIDTH'(candidate)]) begin
                grantFound = 1'b1;
                grantIdx   = REQ_ID_WIDTH'(candidate);
            end
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state       <= IDLE;
            ptr         <= '0;
            latchedId   <= '0;
            latchedAddr <= '0;
            latchedWnr  <= 1'b0;
            waitCount   <= '0;
            req_ready   <= '0;
            rsp_valid   <= '0;
            rsp_success <= 1'b0;
            rsp_timeout <= 1'b0;
            rsp_data    <= '0;
            busy        <= 1'b0;
            sdm_address <= '0;
            sdm_valid   <= 1'b0;
            sdm_wnr     <= 1'b0;
        end else begin
            req_ready <= '0;
            rsp_valid <= '0;
            case (state)
                IDLE: begin
                    busy <= |req_valid;
                    if (grantFound) begin
                        latchedAddr <= reqAddrArr[grantIdx];
                        latchedWnr  <= req_wnr[grantIdx];
                        latchedId   <= grantIdx;
                        req_ready   <= NUM_REQ'(1) << grantIdx;
                        ptr         <= (grantIdx == REQ_ID_WIDTH'(NUM_REQ - 1)) ? '0 : grantIdx + 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    sdm_valid   <= 1'b1;
                    sdm_address <= latchedAddr;
                    sdm_wnr     <= latchedWnr;
                    waitCount   <= '0;
                    state       <= WAIT;
                end
                // A decision arriving together with the last count wins over the timeout.
                WAIT: begin
                    sdm_valid <= 1'b0;
                    if (sdm_readValid) begin
                        rsp_success <= sdm_readSuccess;
                        rsp_data    <= sdm_data;
                        rsp_timeout <= 1'b0;
                        state       <= RESP;
                    end else if (waitCount == TIMEOUT_WIDTH'(TIMEOUT - 1)) begin
                        rsp_success <= 1'b0;
                        rsp_data    <= '0;
                        rsp_timeout <= 1'b1;
                        state       <= RESP;
                    end else begin
                        waitCount <= waitCount + 1'b1;
                    end
                end
                RESP: begin
                    rsp_valid <= NUM_REQ'(1) << latchedId;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdm_request_scheduler.sv
// Self-checking bench for sdm_request_scheduler: directed scenarios plus random traffic,
// compared every cycle against a transaction-age model of the scheduler.
module tb_sdm_request_scheduler;

    localparam int BW      = 512;
    localparam int NREQ    = 4;
    localparam int TIMEOUT = 16;

    logic               clk = 1'b0;
    logic               rstb = 1'b0;
    logic [NREQ-1:0]    reqValid = '0;
    logic [NREQ-1:0]    reqWnr = '0;
    logic [NREQ*BW-1:0] reqAddr = '0;
    logic [NREQ-1:0]    reqReady;
    logic [NREQ-1:0]    rspValid;
    logic               rspSuccess;
    logic               rspTimeout;
    logic [BW-1:0]      rspData;
    logic               busy;
    logic [BW-1:0]      sdmAddress;
    logic               sdmValid;
    logic               sdmWnr;
    logic               sdmReadValid = 1'b0;
    logic               sdmReadSuccess = 1'b0;
    logic [BW-1:0]      sdmData = '0;

    int checkCount = 0;
    int passCount  = 0;

    sdm_request_scheduler #(
        .BIT_WIDTH(BW), .NUM_REQ(NREQ), .REQ_ID_WIDTH(2), .TIMEOUT(TIMEOUT), .TIMEOUT_WIDTH(5)
    ) dut (
        .clk(clk), .rstb(rstb),
        .req_valid(reqValid), .req_wnr(reqWnr), .req_addr(reqAddr), .req_ready(reqReady),
        .rsp_valid(rspValid), .rsp_success(rspSuccess), .rsp_timeout(rspTimeout), .rsp_data(rspData),
        .busy(busy), .sdm_address(sdmAddress), .sdm_valid(sdmValid), .sdm_wnr(sdmWnr),
        .sdm_readValid(sdmReadValid), .sdm_readSuccess(sdmReadSuccess), .sdm_data(sdmData)
    );

    always #5 clk = ~clk;

    // Model: a transaction is tracked by its age in cycles since the grant became visible.
    bit            mInTxn;
    int            mAge, mDecAge, mId, mPtr;
    logic [BW-1:0] mAddr;
    logic          mWnr;
    logic [NREQ-1:0] eReqReady, eRspValid;
    logic          eRspSuccess, eRspTimeout, eBusy, eSdmValid, eSdmWnr;
    logic [BW-1:0] eRspData, eSdmAddr;

    task automatic modelReset();
        mInTxn = 0; mAge = 0; mDecAge = -1; mId = 0; mPtr = 0; mAddr = '0; mWnr = 0;
        eReqReady = '0; eRspValid = '0; eRspSuccess = 0; eRspTimeout = 0; eBusy = 0;
        eSdmValid = 0; eSdmWnr = 0; eRspData = '0; eSdmAddr = '0;
    endtask

    // Advances the model by one clock using the inputs currently driven.
    task automatic modelStep();
        bit found;
        eReqReady = '0; eRspValid = '0; eSdmValid = 0;
        if (!mInTxn) begin
            eBusy = (reqValid != 0);
            found = 0;
            for (int k = 0; k < NREQ; k++) begin
                int idx = (mPtr + k) % NREQ;
                if (!found && reqValid[idx]) begin
                    found = 1;
                    mId = idx;
                    mAddr = reqAddr[idx*BW +: BW];
                    mWnr = reqWnr[idx];
                end
            end
            if (found) begin
                eReqReady = NREQ'(1) << mId;
                mPtr = (mId + 1) % NREQ;
                mInTxn = 1; mAge = 0; mDecAge = -1;
            end
        end else begin
            eBusy = 1;
            if (mAge == 0) begin
                eSdmValid = 1; eSdmAddr = mAddr; eSdmWnr = mWnr;
            end else if (mDecAge < 0) begin
                if (sdmReadValid) begin
                    eRspSuccess = sdmReadSuccess; eRspData = sdmData; eRspTimeout = 0; mDecAge = mAge;
                end else if (mAge == TIMEOUT) begin
                    eRspSuccess = 0; eRspData = '0; eRspTimeout = 1; mDecAge = mAge;
                end
            end else if (mAge == mDecAge + 1) begin
                eRspValid = NREQ'(1) << mId;
                mInTxn = 0;
            end
            mAge++;
        end
    endtask

    task automatic checkVal(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    endtask

    task automatic checkOutput();
        checkVal("req_ready", reqReady, eReqReady);
        checkVal("rsp_valid", rspValid, eRspValid);
        checkVal("rsp_success", rspSuccess, eRspSuccess);
        checkVal("rsp_timeout", rspTimeout, eRspTimeout);
        checkVal("rsp_data", rspData, eRspData);
        checkVal("busy", busy, eBusy);
        checkVal("sdm_valid", sdmValid, eSdmValid);
        checkVal("sdm_wnr", sdmWnr, eSdmWnr);
        checkVal("sdm_address", sdmAddress, eSdmAddr);
    endtask

    task automatic applyStimulus(input logic [NREQ-1:0] v, input logic [NREQ-1:0] w,
                                 input logic rv, input logic rs, input logic [BW-1:0] d);
        reqValid = v; reqWnr = w;
        sdmReadValid = rv; sdmReadSuccess = rs; sdmData = d;
        modelStep();
        @(negedge clk);
        checkOutput();
    endtask

    task automatic idleStep();
        applyStimulus('0, '0, 1'b0, 1'b0, '0);
    endtask

    logic [BW-1:0] patA5, pat3C, pat77;
    int expOrder [5] = '{0, 1, 2, 3, 0};

    initial begin
        patA5 = {64{8'hA5}};
        pat3C = {64{8'h3C}};
        pat77 = {64{8'h77}};
        modelReset();
        @(negedge clk);
        checkOutput();
        checkVal("reset_busy_literal", busy, 1'b0);
        checkVal("reset_sdm_valid_literal", sdmValid, 1'b0);
        rstb = 1'b1;

        // Single read from requester 0, decision on the second WAIT cycle.
        reqAddr[0 +: BW] = patA5;
        applyStimulus(4'b0001, 4'b0000, 1'b0, 1'b0, '0);
        checkVal("read_req_ready", reqReady, 4'b0001);
        idleStep();
        checkVal("read_sdm_valid", sdmValid, 1'b1);
        checkVal("read_sdm_address", sdmAddress, patA5);
        idleStep();
        applyStimulus('0, '0, 1'b1, 1'b1, pat3C);
        idleStep();
        checkVal("read_rsp_valid", rspValid, 4'b0001);
        checkVal("read_rsp_success", rspSuccess, 1'b1);
        checkVal("read_rsp_timeout", rspTimeout, 1'b0);
        checkVal("read_rsp_data", rspData, pat3C);

        // Timeout with a spurious decision during ISSUE; ptr now points at requester 1.
        reqAddr[BW +: BW] = pat77;
        applyStimulus(4'b0010, 4'b0010, 1'b0, 1'b0, '0);
        checkVal("timeout_req_ready", reqReady, 4'b0010);
        applyStimulus('0, '0, 1'b1, 1'b1, pat3C);
        for (int i = 2; i <= 18; i++) begin
            idleStep();
            if (i == 2) checkVal("timeout_sdm_wnr", sdmWnr, 1'b1);
            if (i < 18) checkVal("timeout_no_early_rsp", rspValid, 4'b0000);
        end
        checkVal("timeout_rsp_valid", rspValid, 4'b0010);
        checkVal("timeout_flag", rspTimeout, 1'b1);
        checkVal("timeout_success", rspSuccess, 1'b0);
        checkVal("timeout_data", rspData, '0);

        // Decision on the 16th WAIT cycle must win over the timeout.
        applyStimulus(4'b0100, 4'b0000, 1'b0, 1'b0, '0);
        checkVal("boundary_req_ready", reqReady, 4'b0100);
        for (int i = 1; i <= 18; i++) begin
            if (i == 17) applyStimulus('0, '0, 1'b1, 1'b0, patA5);
            else idleStep();
        end
        checkVal("boundary_rsp_valid", rspValid, 4'b0100);
        checkVal("boundary_timeout", rspTimeout, 1'b0);
        checkVal("boundary_success", rspSuccess, 1'b0);
        checkVal("boundary_data", rspData, patA5);

        // Reset while waiting: everything clears and no response follows.
        applyStimulus(4'b0001, 4'b0001, 1'b0, 1'b0, '0);
        for (int i = 0; i < 4; i++) idleStep();
        rstb = 1'b0;
        modelReset();
        #1;
        checkOutput();
        checkVal("midreset_busy", busy, 1'b0);
        checkVal("midreset_rsp_data", rspData, '0);
        @(negedge clk);
        rstb = 1'b1;
        for (int i = 0; i < 20; i++) begin
            idleStep();
            checkVal("midreset_no_rsp", rspValid, 4'b0000);
        end
        applyStimulus(4'b0100, 4'b0000, 1'b0, 1'b0, '0);
        checkVal("midreset_grant2", reqReady, 4'b0100);

        // Let requester 2 finish, then all four compete; pointer is at 3.
        expOrder = '{3, 0, 1, 2, 3};
        begin
            int grants = 0;
            for (int cyc = 0; cyc < 80 && grants < 5; cyc++) begin
                applyStimulus(4'b1111, 4'b0000, 1'b1, 1'b1, pat3C);
                if (reqReady != 0) begin
                    checkVal("rr_order", reqReady, NREQ'(1) << expOrder[grants]);
                    grants++;
                end
            end
            checkVal("rr_grant_count", 32'(grants), 32'd5);
        end

        // Random traffic against the model.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < NREQ; i++)
                reqAddr[i*BW +: BW] = {16{$urandom}};
            applyStimulus(($urandom_range(0, 3) == 0) ? 4'b0000 : NREQ'($urandom_range(0, 15)),
                          NREQ'($urandom_range(0, 15)),
                          ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)), {16{$urandom}});
        end

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
